// File: rtl/spi_sram_responder.sv
// spi_sram_responder
//   SPI (mode 0) slave front-end for an internal byte-wide SRAM array.
//   All SPI pins are oversampled on i_clk (i_clk must run >= 8x SCK).
//   Commands: 0x03 READ, 0x02 WRITE, 0x05 RDSR, 0x01 WRSR; anything else
//   is ignored until CS deasserts. Status MODE[7:6] selects byte, page
//   or sequential addressing for multi-byte transfers; bit 0 is stored only.
//
// Ports
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_sck       SPI clock (asynchronous to i_clk)
//   i_cs        chip select, active-low
//   i_si        serial data in (master -> slave)
//   o_so        serial data out (slave -> master)
//   o_so_oe     drive enable for o_so, high only while shifting data/status
//   o_wr_pulse  one-cycle strobe per byte committed to the array
`timescale 1ns/1ps
module spi_sram_responder #(
  parameter int ADDR_W = 13,
  parameter int PAGE_W = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sck,
  input  logic i_cs,
  input  logic i_si,
  output logic o_so,
  output logic o_so_oe,
  output logic o_wr_pulse
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDSR, WRSR, IGNORE
  } state_t;

  state_t              state;
  logic [3:0]          bit_cnt;
  logic [1:0]          mode;
  logic                hold;
  logic [1:0]          settle_cnt;

  logic                sck_p0, sck_p1, sck_p2;
  logic                cs_p0, cs_p1, cs_p2;
  logic                si_p0, si_p1;

  logic [7:0]          shift_in;
  logic [7:0]          so_sr;
  logic [ADDR_W-1:0]   addr;
  logic                is_read;
  logic [7:0]          mem [0:(2**ADDR_W)-1];

  logic                sck_rise, sck_fall, cs_fall, byte_mode;
  logic [7:0]          shift_nxt, status;
  logic [ADDR_W-1:0]   addr_shift, addr_adv;

  // Page mode wraps inside the page; every other mode increments the full address.
  function automatic logic [ADDR_W-1:0] adv_addr(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0] m);
    logic [ADDR_W-1:0] r;
    r = a;
    if (m == 2'b10) r[PAGE_W-1:0] = a[PAGE_W-1:0] + PAGE_W'(1);
    else            r = a + ADDR_W'(1);
    return r;
  endfunction

  // Synchronizer stage: _p0/_p1 are the 2-flop sync, _p2 the delayed copy for edges
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_p0     <= 1'b0;
      sck_p1     <= 1'b0;
      sck_p2     <= 1'b0;
      cs_p0      <= 1'b1;
      cs_p1      <= 1'b1;
      cs_p2      <= 1'b1;
      si_p0      <= 1'b0;
      si_p1      <= 1'b0;
      settle_cnt <= 2'd0;
    end else begin
      sck_p0 <= i_sck;
      sck_p1 <= sck_p0;
      sck_p2 <= sck_p1;
      cs_p0  <= i_cs;
      cs_p1  <= cs_p0;
      cs_p2  <= cs_p1;
      si_p0  <= i_si;
      si_p1  <= si_p0;
      if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
    end
  end

  // CS falls are only trusted once the whole chain holds real pin values, so a
  // CS already low across reset release is not mistaken for a new transaction.
  assign sck_rise   = sck_p1 & ~sck_p2;
  assign sck_fall   = ~sck_p1 & sck_p2;
  assign cs_fall    = (settle_cnt == 2'd3) & ~cs_p1 & cs_p2;
  assign shift_nxt  = {shift_in[6:0], si_p1};
  assign addr_shift = {addr[ADDR_W-2:0], si_p1};
  assign addr_adv   = adv_addr(addr, mode);
  assign status     = {mode, 5'b00000, hold};
  assign byte_mode  = (mode == 2'b00) || (mode == 2'b11);

  // Control stage: FSM, bit counter, status register and output pins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      mode       <= 2'b00;
      hold       <= 1'b0;
      o_so       <= 1'b0;
      o_so_oe    <= 1'b0;
      o_wr_pulse <= 1'b0;
    end else begin
      o_wr_pulse <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= 4'd0;
          o_so    <= 1'b0;
          o_so_oe <= 1'b0;
          if (cs_fall) state <= CMD;
        end
        CMD: if (sck_rise) begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt <= 4'd0;
            case (shift_nxt)
              8'h03, 8'h02: state <= ADDR;
              8'h05:        state <= RDSR;
              8'h01:        state <= WRSR;
              default:      state <= IGNORE;
            endcase
          end
        end
        ADDR: if (sck_rise) begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            bit_cnt <= 4'd0;
            state   <= is_read ? RD_DATA : WR_DATA;
          end
        end
        RD_DATA, RDSR: begin
          if (sck_fall) begin
            o_so    <= so_sr[7];
            o_so_oe <= 1'b1;
          end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              // A byte-mode read ends after one byte; the 8th bit has just
              // been sampled by the master, so the driver can be released.
              if (state == RD_DATA && byte_mode) begin
                state   <= IGNORE;
                o_so    <= 1'b0;
                o_so_oe <= 1'b0;
              end
            end
          end
        end
        WR_DATA: if (sck_rise) begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt    <= 4'd0;
            o_wr_pulse <= 1'b1;
            if (byte_mode) state <= IGNORE;
          end
        end
        WRSR: if (sck_rise) begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            mode  <= shift_nxt[7:6];
            hold  <= shift_nxt[0];
            state <= IGNORE;
          end
        end
        IGNORE: begin
          o_so    <= 1'b0;
          o_so_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Deselect wins over everything above except the byte commit, which has
      // already been decided this cycle and must survive a coincident CS rise.
      if (cs_p1) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        o_so    <= 1'b0;
        o_so_oe <= 1'b0;
      end
    end
  end

  // Data stage: shift registers, address register and array (not reset)
  always_ff @(posedge i_clk) begin
    if (sck_rise) begin
      case (state)
        CMD: begin
          shift_in <= shift_nxt;
          if (bit_cnt == 4'd7) begin
            is_read <= (shift_nxt == 8'h03);
            so_sr   <= status;
          end
        end
        ADDR: begin
          addr <= addr_shift;
          if (bit_cnt == 4'd15) so_sr <= mem[addr_shift];
        end
        WR_DATA: begin
          shift_in <= shift_nxt;
          if (bit_cnt == 4'd7) begin
            mem[addr] <= shift_nxt;
            addr      <= addr_adv;
          end
        end
        RD_DATA: if (bit_cnt == 4'd7) begin
          addr  <= addr_adv;
          so_sr <= mem[addr_adv];
        end
        RDSR: if (bit_cnt == 4'd7) so_sr <= status;
        WRSR: shift_in <= shift_nxt;
        default: ;
      endcase
    end else if (sck_fall) begin
      so_sr <= {so_sr[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
`timescale 1ns/1ps
module tb_spi_sram_responder;

  logic i_clk, i_rst_n, i_sck, i_cs, i_si;
  logic o_so, o_so_oe, o_wr_pulse;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_cnt  = 0;
  int   oe_cnt  = 0;

  spi_sram_responder #(.ADDR_W(13), .PAGE_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sck(i_sck), .i_cs(i_cs), .i_si(i_si),
    .o_so(o_so), .o_so_oe(o_so_oe), .o_wr_pulse(o_wr_pulse)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_wr_pulse === 1'b1) wr_cnt++;
    if (o_so_oe === 1'b1) oe_cnt++;
  end

  // SCK half period 50 ns = 5 i_clk, i.e. i_clk = 10x SCK
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      i_si = tx[7-i];
      #50;
      rx[7-i] = o_so;
      i_sck = 1'b1;
      #50;
      i_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_start();
    i_cs = 1'b0;
    #100;
  endtask

  task automatic cs_end();
    #50;
    i_cs = 1'b1;
    #150;
  endtask

  task automatic mem_write(input logic [15:0] a, input int n, input logic [23:0] d);
    logic [7:0] rx;
    cs_start();
    spi_byte(8'h02, rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
    for (int i = 0; i < n; i++) spi_byte(d[23-8*i -: 8], rx);
    cs_end();
  endtask

  task automatic mem_read(input logic [15:0] a, input int n, output logic [23:0] d);
    logic [7:0] rx;
    d = 24'h0;
    cs_start();
    spi_byte(8'h03, rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      d[23-8*i -: 8] = rx;
    end
    cs_end();
  endtask

  task automatic wrsr(input logic [7:0] v);
    logic [7:0] rx;
    cs_start();
    spi_byte(8'h01, rx);
    spi_byte(v, rx);
    cs_end();
  endtask

  task automatic rdsr(output logic [15:0] v);
    logic [7:0] rx;
    cs_start();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    v[15:8] = rx;
    spi_byte(8'h00, rx);
    v[7:0] = rx;
    cs_end();
  endtask

  task automatic test_reset();
    logic [15:0] s;
    n_tests++;
    if (o_so !== 1'b0) begin n_fail++; $display("FAIL reset_so got %b exp 0", o_so); end
    n_tests++;
    if (o_so_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b exp 0", o_so_oe); end
    n_tests++;
    if (o_wr_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b exp 0", o_wr_pulse); end
    i_rst_n = 1'b1;
    #100;
    rdsr(s);
    n_tests++;
    if (s[15:8] !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h exp 00", s[15:8]); end
  endtask

  task automatic test_byte_mode();
    logic [23:0] d;
    int w0;
    mem_write(16'h0124, 1, 24'h770000);
    w0 = wr_cnt;
    mem_write(16'h0123, 2, 24'hA55A00);
    n_tests++;
    if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL byte_wr_pulses got %0d exp 1", wr_cnt - w0); end
    mem_read(16'h0123, 2, d);
    n_tests++;
    if (d[23:16] !== 8'hA5) begin n_fail++; $display("FAIL byte_rd_0123 got %h exp a5", d[23:16]); end
    n_tests++;
    if (d[15:8] !== 8'h00) begin n_fail++; $display("FAIL byte_rd_stop got %h exp 00", d[15:8]); end
    mem_read(16'h0124, 1, d);
    n_tests++;
    if (d[23:16] !== 8'h77) begin n_fail++; $display("FAIL byte_rd_0124 got %h exp 77", d[23:16]); end
  endtask

  task automatic test_status_fields();
    logic [15:0] s;
    wrsr(8'hFF);
    rdsr(s);
    n_tests++;
    if (s[15:8] !== 8'hC1) begin n_fail++; $display("FAIL status_fields got %h exp c1", s[15:8]); end
    wrsr(8'h00);
  endtask

  task automatic test_page_mode();
    logic [15:0] s;
    logic [23:0] d;
    int w0;
    wrsr(8'h80);
    rdsr(s);
    n_tests++;
    if (s[15:8] !== 8'h80) begin n_fail++; $display("FAIL page_rdsr got %h exp 80", s[15:8]); end
    n_tests++;
    if (s[7:0] !== 8'h80) begin n_fail++; $display("FAIL page_rdsr_repeat got %h exp 80", s[7:0]); end
    mem_write(16'h0020, 1, 24'h990000);
    w0 = wr_cnt;
    mem_write(16'h001F, 3, 24'h112233);
    n_tests++;
    if (wr_cnt - w0 !== 3) begin n_fail++; $display("FAIL page_wr_pulses got %0d exp 3", wr_cnt - w0); end
    mem_read(16'h001F, 3, d);
    n_tests++;
    if (d[23:16] !== 8'h11) begin n_fail++; $display("FAIL page_rd_001f got %h exp 11", d[23:16]); end
    n_tests++;
    if (d[15:8] !== 8'h22) begin n_fail++; $display("FAIL page_rd_0000 got %h exp 22", d[15:8]); end
    n_tests++;
    if (d[7:0] !== 8'h33) begin n_fail++; $display("FAIL page_rd_0001 got %h exp 33", d[7:0]); end
    mem_read(16'h0020, 1, d);
    n_tests++;
    if (d[23:16] !== 8'h99) begin n_fail++; $display("FAIL page_rd_0020 got %h exp 99", d[23:16]); end
  endtask

  task automatic test_seq_mode();
    logic [23:0] d;
    int w0;
    wrsr(8'h40);
    w0 = wr_cnt;
    mem_write(16'hFFFF, 2, 24'hDEAD00);
    n_tests++;
    if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL seq_wr_pulses got %0d exp 2", wr_cnt - w0); end
    mem_read(16'h1FFF, 2, d);
    n_tests++;
    if (d[23:16] !== 8'hDE) begin n_fail++; $display("FAIL seq_rd_1fff got %h exp de", d[23:16]); end
    n_tests++;
    if (d[15:8] !== 8'hAD) begin n_fail++; $display("FAIL seq_rd_wrap got %h exp ad", d[15:8]); end
    mem_read(16'h0000, 1, d);
    n_tests++;
    if (d[23:16] !== 8'hAD) begin n_fail++; $display("FAIL seq_rd_0000 got %h exp ad", d[23:16]); end
  endtask

  task automatic test_abort();
    logic [7:0]  rx;
    logic [23:0] d;
    int w0;
    wrsr(8'h00);
    mem_write(16'h0040, 1, 24'h3C0000);
    w0 = wr_cnt;
    cs_start();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h40, rx);
    spi_bits(8'hFF, 5, rx);
    cs_end();
    n_tests++;
    if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL abort_wr_pulses got %0d exp 0", wr_cnt - w0); end
    mem_read(16'h0040, 1, d);
    n_tests++;
    if (d[23:16] !== 8'h3C) begin n_fail++; $display("FAIL abort_rd_0040 got %h exp 3c", d[23:16]); end
  endtask

  task automatic test_cs_commit();
    logic [7:0]  rx;
    logic [7:0]  tx;
    logic [23:0] d;
    int w0;
    tx = 8'h6B;
    w0 = wr_cnt;
    cs_start();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h41, rx);
    spi_bits(tx, 7, rx);
    i_si = tx[0];
    #50;
    i_sck = 1'b1;
    i_cs  = 1'b1;
    #50;
    i_sck = 1'b0;
    #150;
    n_tests++;
    if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL cs_commit_pulses got %0d exp 1", wr_cnt - w0); end
    mem_read(16'h0041, 1, d);
    n_tests++;
    if (d[23:16] !== 8'h6B) begin n_fail++; $display("FAIL cs_commit_rd got %h exp 6b", d[23:16]); end
  endtask

  task automatic test_unknown_cmd();
    logic [7:0]  rx;
    logic [15:0] s;
    logic [23:0] d;
    int w0, o0;
    wrsr(8'h40);
    w0 = wr_cnt;
    o0 = oe_cnt;
    cs_start();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 4; i++) spi_byte(8'h01, rx);
    cs_end();
    n_tests++;
    if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL unk_oe_cycles got %0d exp 0", oe_cnt - o0); end
    n_tests++;
    if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL unk_wr_pulses got %0d exp 0", wr_cnt - w0); end
    rdsr(s);
    n_tests++;
    if (s[15:8] !== 8'h40) begin n_fail++; $display("FAIL unk_status got %h exp 40", s[15:8]); end
    mem_read(16'h0040, 1, d);
    n_tests++;
    if (d[23:16] !== 8'h3C) begin n_fail++; $display("FAIL unk_rd_0040 got %h exp 3c", d[23:16]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  rx;
    logic [15:0] s;
    logic [23:0] d;
    int w0, o0;
    wrsr(8'h80);
    cs_start();
    spi_byte(8'h03, rx);
    spi_bits(8'h01, 5, rx);
    i_rst_n = 1'b0;
    #30;
    n_tests++;
    if ({o_so, o_so_oe, o_wr_pulse} !== 3'b000)
      begin n_fail++; $display("FAIL rstmid_in_reset got %b exp 000", {o_so, o_so_oe, o_wr_pulse}); end
    #50;
    i_rst_n = 1'b1;
    #100;
    n_tests++;
    if ({o_so, o_so_oe, o_wr_pulse} !== 3'b000)
      begin n_fail++; $display("FAIL rstmid_released got %b exp 000", {o_so, o_so_oe, o_wr_pulse}); end
    // CS still low from before reset: clocking an RDSR must not be answered
    o0 = oe_cnt;
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    cs_end();
    n_tests++;
    if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL rstmid_no_fresh_fall got %0d exp 0", oe_cnt - o0); end
    rdsr(s);
    n_tests++;
    if (s[15:8] !== 8'h00) begin n_fail++; $display("FAIL rstmid_status got %h exp 00", s[15:8]); end
    w0 = wr_cnt;
    mem_write(16'h0100, 1, 24'h420000);
    n_tests++;
    if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL rstmid_wr_pulses got %0d exp 1", wr_cnt - w0); end
    mem_read(16'h0100, 1, d);
    n_tests++;
    if (d[23:16] !== 8'h42) begin n_fail++; $display("FAIL rstmid_rd_0100 got %h exp 42", d[23:16]); end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_cs    = 1'b1;
    i_sck   = 1'b0;
    i_si    = 1'b0;
    #40;
    test_reset();
    test_byte_mode();
    test_status_fields();
    test_page_mode();
    test_seq_mode();
    test_abort();
    test_cs_commit();
    test_unknown_cmd();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sram_responder.md
SPI_SRAM_RESPONDER -- requirements
Module: x_spi_sram_responder

Interface
REQ-001 Parameter ADDR_W, default 13: array address width; depth is 2^ADDR_W bytes, giving 8 KB by default.
REQ-002 Parameter PAGE_W, default 5: page size is 2^PAGE_W bytes, giving 32 by default.
REQ-003 i_clk  in  1  system clock; one clock domain; SPI inputs are oversampled on it.
REQ-004 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 i_sck  in  1  SPI clock from the master; asynchronous to i_clk.
REQ-006 i_cs  in  1  chip select, active-low; high means deselected.
REQ-007 i_si  in  1  serial data from the master.
REQ-008 o_so  out  1  serial data to the master.
REQ-009 o_so_oe  out  1  SO drive enable; high only while data or status is being shifted out.
REQ-010 o_wr_pulse  out  1  one i_clk strobe on each byte committed to the array.

Function
REQ-011 i_sck, i_cs and i_si SHALL each pass through a 2-flop synchronizer; SCK rise/fall SHALL be detected from the synchronized value and its 1-cycle-delayed copy.
REQ-012 Correct operation SHALL be guaranteed for i_clk >= 8x SCK frequency.
REQ-013 SPI mode 0 SHALL be used: SI sampled on SCK rise, SO updated on SCK fall, MSB first.
REQ-014 The FSM SHALL have states IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDSR, WRSR and IGNORE.
REQ-015 IDLE: while CS is high (synchronized), the FSM SHALL stay in IDLE, the bit counter SHALL be 0, o_so_oe=0 and o_so=0.
REQ-016 IDLE->CMD SHALL occur on the synchronized CS fall.
REQ-017 CMD SHALL shift 8 bits, and on the 8th rise SHALL decode:
- 0x03 -> ADDR (read)
- 0x02 -> ADDR (write)
- 0x05 -> RDSR
- 0x01 -> WRSR
- any other value -> IGNORE
REQ-018 ADDR SHALL shift 16 bits MSB first; only bits [ADDR_W-1:0] SHALL be kept and upper bits ignored. On the 16th rise the FSM SHALL go to RD_DATA or WR_DATA.
REQ-019 RD_DATA: the array byte at the current address SHALL be loaded into the shift register on the last address rise.
REQ-020 RD_DATA: o_so_oe=1 and bit 7 SHALL appear on o_so at the following SCK fall, then one bit per fall.
REQ-021 RD_DATA: after 8 bits the address SHALL advance per mode (REQ-026), and the next byte SHALL be loaded in time for the next fall.
REQ-022 WR_DATA: bits SHALL shift in on rises; on the 8th rise the byte SHALL be written to the current address, o_wr_pulse SHALL pulse for 1 cycle, and the address SHALL advance per mode.
REQ-023 Status register fields:
- bits 7:6 MODE: 00 byte, 10 page, 01 sequential, 11 treated as byte
- bit 0 HOLD-disable: stored only, no function
- bits 5:1 read as 0
REQ-024 RDSR SHALL shift status out on falls, repeating status for every further 8 clocks.
REQ-025 WRSR SHALL update bits 7:6 and 0 on the 8th rise of the first data byte; further bytes SHALL be ignored.
REQ-026 Address advance by mode:
- byte mode: after one data byte the FSM SHALL enter IGNORE; no further writes, o_so_oe=0.
- page mode: the low PAGE_W bits SHALL increment and wrap within the page (0x1F -> 0x00 of the same page); high bits unchanged.
- sequential mode: the full ADDR_W address SHALL increment and wrap from 2^ADDR_W-1 to 0.
REQ-027 IGNORE SHALL hold o_so_oe=0, perform no array or status access, and be left only on CS rise.
REQ-028 A CS rise from any state SHALL return the FSM to IDLE within 3 i_clk.
REQ-029 On such a CS rise, a partial write byte (<8 bits) SHALL be discarded and a partial command or address SHALL have no effect.
REQ-030 A CS rise coincident with the 8th data rise SHALL still commit that byte.
REQ-031 o_so SHALL change within 3 i_clk of the SCK fall at the pins.
REQ-032 o_wr_pulse SHALL assert within 3 i_clk of the committing SCK rise.

Reset
REQ-033 While i_rst_n=0: FSM=IDLE, counters=0, status=0x00 (byte mode), o_so=0, o_so_oe=0, o_wr_pulse=0, synchronizer flops reset with CS flops set to 1.
REQ-034 Array contents SHALL NOT be reset and SHALL be undefined until written.
REQ-035 Reset asserted mid-transaction SHALL abort it with no array write; after release the block SHALL require a fresh CS fall.

Verification
REQ-036 Byte mode: WRITE 0x02, addr 0x0123, data 0xA5, 0x5A; then READ 0x03, addr 0x0123 -> 0xA5 read back, exactly one o_wr_pulse, 0x0124 unchanged.
REQ-037 Page mode: WRSR 0x80; RDSR -> 0x80. Write 0x11,0x22,0x33 from addr 0x001F -> 0x001F=0x11, 0x0000=0x22, 0x0001=0x33, 0x0020 untouched.
REQ-038 Sequential mode: WRSR 0x40; write 0xDE,0xAD from 0x1FFF -> 0x1FFF=0xDE, 0x0000=0xAD. Address 0xFFFF with ADDR_W=13 SHALL map to 0x1FFF.
REQ-039 Abort: CS raised after 5 bits of the data byte in a write to 0x0040 -> 0x0040 keeps its prior value and no o_wr_pulse occurs.
REQ-040 Unknown command 0x9F followed by 32 clocks -> o_so_oe stays 0 and the array and status are unchanged.
REQ-041 Reset: i_rst_n low during a READ address phase, then release -> all outputs 0, status reads 0x00, and the next transaction completes normally.
